// File: rtl/tilemap_sr_pkg.sv
// rtl/tilemap_sr_pkg.sv - default geometry, pixel type and flat-bus lane slicing for the tilemap serialiser
package tilemap_sr_pkg;
  localparam int DEF_LAYERS    = 2;
  localparam int DEF_PX        = 8;
  localparam int DEF_BPP       = 4;
  localparam int DEF_OUT_DELAY = 3;
  localparam int BUS_MAX       = 1024;

  typedef logic [DEF_BPP-1:0] pixel_t;

  // Returns lane `lane` of a flat bus whose lanes are `width` bits each, right-aligned.
  function automatic logic [BUS_MAX-1:0] lane_slice(input logic [BUS_MAX-1:0] bus,
                                                    input int lane, input int width);
    logic [BUS_MAX-1:0] mask;
    mask = (BUS_MAX'(1) << width) - BUS_MAX'(1);
    return (bus >> (lane * width)) & mask;
  endfunction
endpackage

// File: rtl/tilemap_sr_array_if.sv
// rtl/tilemap_sr_array_if.sv - strobe, data and pixel-output bundle between timing/fetch and the serialiser
interface tilemap_sr_array_if
  import tilemap_sr_pkg::*;
#(
  parameter int LAYERS = DEF_LAYERS,
  parameter int PX     = DEF_PX,
  parameter int BPP    = DEF_BPP,
  parameter int FW     = $clog2(PX)
);
  logic                       i_EMU_CLK6MPCEN_n;
  logic [LAYERS*PX*BPP-1:0]   i_GFXDATA;
  logic [LAYERS-1:0]          i_LATCH;
  logic [LAYERS-1:0]          i_LOAD;
  logic [LAYERS-1:0]          i_FLIP;
  logic [LAYERS*FW-1:0]       i_FINE;
  logic                       i_HOLD;
  logic [LAYERS*BPP-1:0]      o_PIXEL;
  logic [LAYERS-1:0]          o_TRN_n;

  modport master (
    output i_EMU_CLK6MPCEN_n, i_GFXDATA, i_LATCH, i_LOAD, i_FLIP, i_FINE, i_HOLD,
    input  o_PIXEL, o_TRN_n
  );

  modport slave (
    input  i_EMU_CLK6MPCEN_n, i_GFXDATA, i_LATCH, i_LOAD, i_FLIP, i_FINE, i_HOLD,
    output o_PIXEL, o_TRN_n
  );
endinterface

// File: rtl/tilemap_sr_lane.sv
// rtl/tilemap_sr_lane.sv - one tilemap lane: line latch, bidirectional pixel SR, flip capture,
// fine-scroll delay line and output pipeline.
module tilemap_sr_lane #(
  parameter int PX        = 8,
  parameter int BPP       = 4,
  parameter int OUT_DELAY = 3,
  parameter int FW        = $clog2(PX)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cen_n,
  input  logic [PX*BPP-1:0] i_gfx,
  input  logic              i_latch,
  input  logic              i_load,
  input  logic              i_flip,
  input  logic [FW-1:0]     i_fine,
  input  logic              i_hold,
  output logic [BPP-1:0]    o_pixel
);
  logic [PX*BPP-1:0] r_latch;
  logic [BPP-1:0]    r_sr   [PX];
  logic              r_flip;
  logic [BPP-1:0]    r_dly  [PX-1];
  logic [BPP-1:0]    r_pipe [OUT_DELAY+1];
  logic [BPP-1:0]    w_head;
  logic [BPP-1:0]    w_tap;
  logic              w_cen;

  assign w_cen  = ~i_cen_n;
  assign w_head = r_flip ? r_sr[PX-1] : r_sr[0];

  always_comb begin
    w_tap = w_head;
    for (int k = 1; k < PX; k++) begin
      if (i_fine == FW'(k)) w_tap = r_dly[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_latch <= '0;
    end else if (w_cen && i_latch) begin
      r_latch <= i_gfx;
    end
  end

  // Load reads the pre-edge latch, so a same-edge latch+load loads the previous row.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flip <= 1'b0;
      for (int j = 0; j < PX; j++) r_sr[j] <= '0;
    end else if (w_cen) begin
      if (i_load) begin
        r_flip <= i_flip;
        for (int j = 0; j < PX; j++) r_sr[j] <= r_latch[(PX-1-j)*BPP +: BPP];
      end else if (!i_hold) begin
        if (r_flip) begin
          r_sr[0] <= '0;
          for (int j = 1; j < PX; j++) r_sr[j] <= r_sr[j-1];
        end else begin
          for (int j = 0; j < PX-1; j++) r_sr[j] <= r_sr[j+1];
          r_sr[PX-1] <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < PX-1; k++) r_dly[k] <= '0;
    end else if (w_cen && !i_hold) begin
      r_dly[0] <= w_head;
      for (int k = 1; k < PX-1; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  // The output pipeline ignores hold so the mixer keeps receiving a steady stream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k <= OUT_DELAY; k++) r_pipe[k] <= '0;
    end else if (w_cen) begin
      r_pipe[0] <= w_tap;
      for (int k = 1; k <= OUT_DELAY; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_pixel = r_pipe[OUT_DELAY];
endmodule

// File: rtl/tilemap_sr_array.sv
// rtl/tilemap_sr_array.sv - multi-lane tilemap pixel serialiser; slices the flat buses and
// instantiates one tilemap_sr_lane per layer.
module tilemap_sr_array
  import tilemap_sr_pkg::*;
#(
  parameter int LAYERS    = DEF_LAYERS,
  parameter int PX        = DEF_PX,
  parameter int BPP       = DEF_BPP,
  parameter int OUT_DELAY = DEF_OUT_DELAY,
  parameter int FW        = $clog2(PX)
) (
  input  logic               i_EMU_MCLK,
  input  logic               i_EMU_RST_n,
  tilemap_sr_array_if.slave  bus
);
  localparam int LW = PX * BPP;

  for (genvar l = 0; l < LAYERS; l++) begin : g_lane
    logic [LW-1:0]  w_gfx;
    logic [BPP-1:0] w_pix;

    assign w_gfx = LW'(lane_slice(BUS_MAX'(bus.i_GFXDATA), l, LW));

    tilemap_sr_lane #(
      .PX        (PX),
      .BPP       (BPP),
      .OUT_DELAY (OUT_DELAY),
      .FW        (FW)
    ) u_lane (
      .i_clk   (i_EMU_MCLK),
      .i_rst_n (i_EMU_RST_n),
      .i_cen_n (bus.i_EMU_CLK6MPCEN_n),
      .i_gfx   (w_gfx),
      .i_latch (bus.i_LATCH[l]),
      .i_load  (bus.i_LOAD[l]),
      .i_flip  (bus.i_FLIP[l]),
      .i_fine  (bus.i_FINE[l*FW +: FW]),
      .i_hold  (bus.i_HOLD),
      .o_pixel (w_pix)
    );

    assign bus.o_PIXEL[l*BPP +: BPP] = w_pix;
    assign bus.o_TRN_n[l]            = |w_pix;
  end
endmodule
